// File: rtl/yutorina_ex_stage_pkg.sv
// Shared encodings for the Yutorina execute stage: ALU/MD opcodes, memory and
// control op codes, exception codes and the multiply/divide FSM states.
// Latency: n/a (definitions only). Backpressure: n/a.
package yutorina_ex_stage_pkg;

  localparam int WORD_W = 32;

  // ALU operation bus
  localparam logic [3:0] ALU_OP_THR  = 4'h0;
  localparam logic [3:0] ALU_OP_AND  = 4'h1;
  localparam logic [3:0] ALU_OP_OR   = 4'h2;
  localparam logic [3:0] ALU_OP_XOR  = 4'h3;
  localparam logic [3:0] ALU_OP_ADDS = 4'h4;
  localparam logic [3:0] ALU_OP_ADDU = 4'h5;
  localparam logic [3:0] ALU_OP_SUBS = 4'h6;
  localparam logic [3:0] ALU_OP_SUBU = 4'h7;
  localparam logic [3:0] ALU_OP_SRL  = 4'h8;
  localparam logic [3:0] ALU_OP_SLL  = 4'h9;
  localparam logic [3:0] ALU_OP_SRA  = 4'hA;
  localparam logic [3:0] ALU_OP_MUL  = 4'hC;
  localparam logic [3:0] ALU_OP_DIVU = 4'hD;
  localparam logic [3:0] ALU_OP_REMU = 4'hE;

  // Memory operation bus
  localparam logic [1:0] MEM_OP_NOP = 2'h0;
  localparam logic [1:0] MEM_OP_LDW = 2'h1;
  localparam logic [1:0] MEM_OP_STW = 2'h2;

  // Control operation bus
  localparam logic [1:0] CTRL_NONE = 2'h0;
  localparam logic [1:0] CTRL_RDCR = 2'h1;
  localparam logic [1:0] CTRL_WRCR = 2'h2;

  // Exception bus
  localparam logic [2:0] EXP_NONE       = 3'h0;
  localparam logic [2:0] EXP_UNDEF_INSN = 3'h2;
  localparam logic [2:0] EXP_OVERFLOW   = 3'h3;

  // Multiply/divide FSM
  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  function automatic logic is_md_op(input logic [3:0] op);
    return (op == ALU_OP_MUL) || (op == ALU_OP_DIVU) || (op == ALU_OP_REMU);
  endfunction

endpackage

// File: rtl/yutorina_alu.sv
// Single-cycle ALU: logic, add/sub (with signed overflow flag) and shifts.
// Latency: combinational. Backpressure: none.
// Ports: op/in_0/in_1 in; out = result, ovf = signed overflow for ADDS/SUBS.
module yutorina_alu
  import yutorina_ex_stage_pkg::*;
(
  input  logic [3:0]        op,
  input  logic [WORD_W-1:0] in_0,
  input  logic [WORD_W-1:0] in_1,
  output logic [WORD_W-1:0] out,
  output logic              ovf
);

  logic [WORD_W-1:0] sum;
  logic [WORD_W-1:0] diff;

  assign sum  = in_0 + in_1;
  assign diff = in_0 - in_1;

  always_comb begin
    out = '0;
    ovf = 1'b0;
    case (op)
      ALU_OP_THR:  out = in_0;
      ALU_OP_AND:  out = in_0 & in_1;
      ALU_OP_OR:   out = in_0 | in_1;
      ALU_OP_XOR:  out = in_0 ^ in_1;
      ALU_OP_ADDU: out = sum;
      ALU_OP_SUBU: out = diff;
      ALU_OP_ADDS: begin
        out = sum;
        // same-sign operands producing a result of the other sign
        ovf = (in_0[31] == in_1[31]) && (sum[31] != in_0[31]);
      end
      ALU_OP_SUBS: begin
        out = diff;
        ovf = (in_0[31] != in_1[31]) && (diff[31] != in_0[31]);
      end
      ALU_OP_SLL:  out = in_0 << in_1[4:0];
      ALU_OP_SRL:  out = in_0 >> in_1[4:0];
      ALU_OP_SRA:  out = WORD_W'($signed(in_0) >>> in_1[4:0]);
      default:     out = '0;
    endcase
  end

endmodule

// File: rtl/yutorina_md.sv
// Iterative shift-add multiplier / restoring divider (MUL, DIVU, REMU).
// Latency: 1 start + MD_CYCLES run cycles, result held in DONE until stall=0.
// Backpressure: stall freezes the FSM; flush aborts to IDLE; busy is high from start through RUN.
module yutorina_md
  import yutorina_ex_stage_pkg::*;
#(
  parameter int MD_CYCLES = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              start_req,
  input  logic [3:0]        op,
  input  logic [WORD_W-1:0] in_0,
  input  logic [WORD_W-1:0] in_1,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] result
);

  localparam int CNT_W = (MD_CYCLES > 1) ? $clog2(MD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_CYCLES - 1);

  md_state_t         state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [3:0]        op_q;
  // MUL: a_q = shifted multiplicand, b_q = shifted multiplier, acc_q = product.
  // DIV: a_q = dividend shifting out / quotient shifting in, b_q = divisor,
  //      acc_q = partial remainder.
  logic [WORD_W-1:0] a_q, b_q, acc_q;
  logic [WORD_W-1:0] a_step, b_step, acc_step;
  logic [WORD_W:0]   rem_sh;
  logic [WORD_W-1:0] rem_diff;
  logic              rem_ge;
  logic              start;

  always_comb begin
    rem_sh   = {acc_q, a_q[WORD_W-1]};
    rem_ge   = rem_sh >= {1'b0, b_q};
    // when rem_ge holds the true difference fits in a word
    rem_diff = rem_sh[WORD_W-1:0] - b_q;
    a_step   = a_q;
    b_step   = b_q;
    acc_step = acc_q;
    if (op_q == ALU_OP_MUL) begin
      acc_step = b_q[0] ? (acc_q + a_q) : acc_q;
      a_step   = a_q << 1;
      b_step   = b_q >> 1;
    end else if (rem_ge) begin
      acc_step = rem_diff;
      a_step   = {a_q[WORD_W-2:0], 1'b1};
    end else begin
      acc_step = rem_sh[WORD_W-1:0];
      a_step   = {a_q[WORD_W-2:0], 1'b0};
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    start     = 1'b0;
    case (state)
      MD_IDLE: begin
        // nothing starts while reset is asserted, so busy reads 0 in reset
        if (rst && start_req && !flush && !stall) begin
          start     = 1'b1;
          busy      = 1'b1;
          state_nxt = MD_RUN;
        end
      end
      MD_RUN: begin
        busy = !flush;
        if (flush)
          state_nxt = MD_IDLE;
        else if (!stall && (cnt == CNT_LAST))
          state_nxt = MD_DONE;
      end
      MD_DONE: begin
        // the stage registers the result on the first unstalled cycle
        if (flush || !stall)
          state_nxt = MD_IDLE;
      end
      default: state_nxt = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= MD_IDLE;
      cnt   <= '0;
      op_q  <= ALU_OP_THR;
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        op_q  <= op;
        a_q   <= in_0;
        b_q   <= in_1;
        acc_q <= '0;
        cnt   <= '0;
      end else if ((state == MD_RUN) && !stall && !flush) begin
        a_q   <= a_step;
        b_q   <= b_step;
        acc_q <= acc_step;
        cnt   <= cnt + 1'b1;
      end
    end
  end

  assign done   = (state == MD_DONE);
  assign result = (op_q == ALU_OP_DIVU) ? a_q : acc_q;

endmodule

// File: rtl/yutorina_ex_stage.sv
// Yutorina execute stage: ALU/MD result mux, ex_* pipeline register to MEM, forwarding to ID.
// Latency: 1 cycle for ALU ops; MUL/DIVU/REMU 34 cycles issue to ex_* valid.
// Backpressure: stall holds ex_* and the MD FSM; busy bubbles ex_* and asks the controller to hold IF/ID.
// Ports: clk/rst, stall/flush/busy, id_* instruction fields in, ex_* registered out, fwd_* combinational out.
module yutorina_ex_stage
  import yutorina_ex_stage_pkg::*;
#(
  parameter int MD_CYCLES = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  output logic              busy,
  input  logic              id_en_,
  input  logic [3:0]        id_alu_op,
  input  logic [WORD_W-1:0] id_alu_in_0,
  input  logic [WORD_W-1:0] id_alu_in_1,
  input  logic [4:0]        id_w_addr,
  input  logic              id_gpr_we_,
  input  logic [WORD_W-1:0] id_w_data,
  input  logic [1:0]        id_mem_op,
  input  logic [1:0]        id_ctrl_op,
  input  logic [2:0]        id_exp_code,
  output logic              ex_en_,
  output logic [4:0]        ex_w_addr,
  output logic [WORD_W-1:0] ex_w_data,
  output logic              ex_gpr_we_,
  output logic [2:0]        ex_exp_code,
  output logic [1:0]        ex_mem_op,
  output logic [1:0]        ex_ctrl_op,
  output logic [WORD_W-1:0] ex_out,
  output logic [4:0]        fwd_addr,
  output logic              fwd_we_,
  output logic [WORD_W-1:0] fwd_out
);

  logic [WORD_W-1:0] alu_out;
  logic              alu_ovf;
  logic [WORD_W-1:0] md_result;
  logic              md_done;
  logic [WORD_W-1:0] result;
  logic              ovf;

  yutorina_alu u_alu (
    .op   (id_alu_op),
    .in_0 (id_alu_in_0),
    .in_1 (id_alu_in_1),
    .out  (alu_out),
    .ovf  (alu_ovf)
  );

  yutorina_md #(
    .MD_CYCLES (MD_CYCLES)
  ) u_md (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .flush     (flush),
    .start_req (!id_en_ && is_md_op(id_alu_op)),
    .op        (id_alu_op),
    .in_0      (id_alu_in_0),
    .in_1      (id_alu_in_1),
    .busy      (busy),
    .done      (md_done),
    .result    (md_result)
  );

  // ID still presents the MD instruction during DONE, so its fields pair with md_result
  assign result = md_done ? md_result : alu_out;
  assign ovf    = alu_ovf && !id_en_;

  assign fwd_addr = id_w_addr;
  assign fwd_out  = result;
  assign fwd_we_  = !(!id_en_ && !id_gpr_we_ && !busy && !flush && !ovf);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_en_      <= 1'b1;
      ex_w_addr   <= '0;
      ex_w_data   <= '0;
      ex_gpr_we_  <= 1'b1;
      ex_exp_code <= EXP_NONE;
      ex_mem_op   <= MEM_OP_NOP;
      ex_ctrl_op  <= CTRL_NONE;
      ex_out      <= '0;
    end else if (!stall) begin
      if (flush || busy) begin
        ex_en_      <= 1'b1;
        ex_w_addr   <= '0;
        ex_w_data   <= '0;
        ex_gpr_we_  <= 1'b1;
        ex_exp_code <= EXP_NONE;
        ex_mem_op   <= MEM_OP_NOP;
        ex_ctrl_op  <= CTRL_NONE;
        ex_out      <= '0;
      end else begin
        // an overflowed instruction keeps ex_en_ but writes nothing back
        ex_en_      <= id_en_;
        ex_w_addr   <= id_w_addr;
        ex_w_data   <= id_w_data;
        ex_gpr_we_  <= id_en_ | id_gpr_we_ | ovf;
        ex_exp_code <= ovf ? EXP_OVERFLOW : id_exp_code;
        ex_mem_op   <= id_mem_op;
        ex_ctrl_op  <= id_ctrl_op;
        ex_out      <= ovf ? '0 : result;
      end
    end
  end

endmodule

// File: tb/tb_yutorina_ex_stage.sv
module tb_yutorina_ex_stage;
  import yutorina_ex_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic        busy;
  logic        id_en_;
  logic [3:0]  id_alu_op;
  logic [31:0] id_alu_in_0, id_alu_in_1;
  logic [4:0]  id_w_addr;
  logic        id_gpr_we_;
  logic [31:0] id_w_data;
  logic [1:0]  id_mem_op, id_ctrl_op;
  logic [2:0]  id_exp_code;
  logic        ex_en_;
  logic [4:0]  ex_w_addr;
  logic [31:0] ex_w_data;
  logic        ex_gpr_we_;
  logic [2:0]  ex_exp_code;
  logic [1:0]  ex_mem_op, ex_ctrl_op;
  logic [31:0] ex_out;
  logic [4:0]  fwd_addr;
  logic        fwd_we_;
  logic [31:0] fwd_out;

  always #5 clk = ~clk;

  yutorina_ex_stage dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .flush       (flush),
    .busy        (busy),
    .id_en_      (id_en_),
    .id_alu_op   (id_alu_op),
    .id_alu_in_0 (id_alu_in_0),
    .id_alu_in_1 (id_alu_in_1),
    .id_w_addr   (id_w_addr),
    .id_gpr_we_  (id_gpr_we_),
    .id_w_data   (id_w_data),
    .id_mem_op   (id_mem_op),
    .id_ctrl_op  (id_ctrl_op),
    .id_exp_code (id_exp_code),
    .ex_en_      (ex_en_),
    .ex_w_addr   (ex_w_addr),
    .ex_w_data   (ex_w_data),
    .ex_gpr_we_  (ex_gpr_we_),
    .ex_exp_code (ex_exp_code),
    .ex_mem_op   (ex_mem_op),
    .ex_ctrl_op  (ex_ctrl_op),
    .ex_out      (ex_out),
    .fwd_addr    (fwd_addr),
    .fwd_we_     (fwd_we_),
    .fwd_out     (fwd_out)
  );

  typedef struct packed {
    logic        en_;
    logic [4:0]  w_addr;
    logic        gpr_we_;
    logic [2:0]  exp;
    logic [1:0]  mem;
    logic [1:0]  ctrl;
    logic [31:0] w_data;
    logic [31:0] out;
  } ex_t;

  localparam ex_t RST_EX = '{en_: 1'b1, w_addr: 5'd0, gpr_we_: 1'b1, exp: EXP_NONE,
                             mem: MEM_OP_NOP, ctrl: CTRL_NONE, w_data: 32'd0, out: 32'd0};

  localparam int NV = 14;
  localparam logic [3:0] T_OP [NV] = '{ALU_OP_ADDU, ALU_OP_SUBU, ALU_OP_ADDS, ALU_OP_SUBS,
                                       ALU_OP_ADDS, ALU_OP_AND, ALU_OP_OR, ALU_OP_XOR,
                                       ALU_OP_THR, ALU_OP_SLL, ALU_OP_SRL, ALU_OP_SRA,
                                       ALU_OP_ADDU, ALU_OP_SUBS};
  localparam logic [31:0] T_A [NV] = '{32'd3, 32'd0, 32'h7FFFFFFF, 32'h80000000,
                                       32'hFFFFFFFF, 32'h0000F0F0, 32'h0000F0F0, 32'h0000F0F0,
                                       32'h12345678, 32'd1, 32'h80000000, 32'h80000000,
                                       32'd10, 32'd5};
  localparam logic [31:0] T_B [NV] = '{32'd4, 32'd1, 32'd1, 32'd1,
                                       32'd2, 32'h0000FF00, 32'h0000FF00, 32'h0000FF00,
                                       32'hDEADBEEF, 32'h0000003F, 32'd4, 32'd4,
                                       32'd20, 32'd7};
  localparam logic T_EN [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  ex_t sb[$];
  int  checks = 0;
  int  errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en_, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] wa, input logic we_,
                       input logic [31:0] wd, input logic [1:0] mem, input logic [1:0] ctrl,
                       input logic [2:0] exp);
    id_en_      = en_;
    id_alu_op   = op;
    id_alu_in_0 = a;
    id_alu_in_1 = b;
    id_w_addr   = wa;
    id_gpr_we_  = we_;
    id_w_data   = wd;
    id_mem_op   = mem;
    id_ctrl_op  = ctrl;
    id_exp_code = exp;
  endtask

  task automatic drive_idle();
    drive(1'b1, ALU_OP_THR, 32'd0, 32'd0, 5'd0, 1'b1, 32'd0, MEM_OP_NOP, CTRL_NONE, EXP_NONE);
  endtask

  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic ovf);
    logic signed [32:0] s;
    logic [63:0] p;
    r   = 32'd0;
    ovf = 1'b0;
    s   = '0;
    p   = '0;
    case (op)
      ALU_OP_ADDU: r = a + b;
      ALU_OP_SUBU: r = a - b;
      ALU_OP_ADDS: begin
        s = $signed({a[31], a}) + $signed({b[31], b});
        r = s[31:0];
        ovf = s[32] ^ s[31];
      end
      ALU_OP_SUBS: begin
        s = $signed({a[31], a}) - $signed({b[31], b});
        r = s[31:0];
        ovf = s[32] ^ s[31];
      end
      ALU_OP_AND:  r = a & b;
      ALU_OP_OR:   r = a | b;
      ALU_OP_XOR:  r = a ^ b;
      ALU_OP_THR:  r = a;
      ALU_OP_SLL:  r = a << b[4:0];
      ALU_OP_SRL:  r = a >> b[4:0];
      ALU_OP_SRA:  r = 32'($signed(a) >>> b[4:0]);
      ALU_OP_MUL: begin
        p = 64'(a) * 64'(b);
        r = p[31:0];
      end
      ALU_OP_DIVU: r = (b == 32'd0) ? 32'hFFFFFFFF : a / b;
      ALU_OP_REMU: r = (b == 32'd0) ? a : a % b;
      default:     r = 32'd0;
    endcase
  endfunction

  // expected ex_* for the instruction currently driven on id_*
  function automatic ex_t expect_now();
    ex_t e;
    logic [31:0] r;
    logic ovf;
    model(id_alu_op, id_alu_in_0, id_alu_in_1, r, ovf);
    ovf       = ovf && !id_en_;
    e.en_     = id_en_;
    e.w_addr  = id_w_addr;
    e.gpr_we_ = id_en_ | id_gpr_we_ | ovf;
    e.exp     = ovf ? EXP_OVERFLOW : id_exp_code;
    e.mem     = id_mem_op;
    e.ctrl    = id_ctrl_op;
    e.w_data  = id_w_data;
    e.out     = ovf ? 32'd0 : r;
    return e;
  endfunction

  function automatic ex_t dut_ex();
    ex_t e;
    e.en_     = ex_en_;
    e.w_addr  = ex_w_addr;
    e.gpr_we_ = ex_gpr_we_;
    e.exp     = ex_exp_code;
    e.mem     = ex_mem_op;
    e.ctrl    = ex_ctrl_op;
    e.w_data  = ex_w_data;
    e.out     = ex_out;
    return e;
  endfunction

  task automatic test_reset();
    rst   = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    drive_idle();
    repeat (2) tick();
    checks++;
    if (dut_ex() !== RST_EX) begin
      errors++;
      $display("FAIL reset_ex: got %h expected %h", dut_ex(), RST_EX);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b expected 0", busy);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_alu();
    ex_t e, got;
    logic [31:0] r;
    logic ovf, exp_we;
    for (int i = 0; i < NV; i++) begin
      drive(T_EN[i], T_OP[i], T_A[i], T_B[i], 5'(i + 1), 1'b0, 32'h1000 + 32'(i),
            2'(i % 3), 2'((i + 1) % 3), (i == 8) ? EXP_UNDEF_INSN : EXP_NONE);
      e = expect_now();
      sb.push_back(e);
      model(T_OP[i], T_A[i], T_B[i], r, ovf);
      exp_we = !(!T_EN[i] && !ovf);
      #1;
      checks++;
      if (fwd_we_ !== exp_we || fwd_addr !== 5'(i + 1)) begin
        errors++;
        $display("FAIL alu_fwd_we[%0d]: got we_=%b addr=%0d expected we_=%b addr=%0d",
                 i, fwd_we_, fwd_addr, exp_we, i + 1);
      end
      if (!exp_we) begin
        checks++;
        if (fwd_out !== r) begin
          errors++;
          $display("FAIL alu_fwd_out[%0d]: got %h expected %h", i, fwd_out, r);
        end
      end
      tick();
      got = dut_ex();
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL alu_ex[%0d]: got %h expected %h", i, got, e);
      end
    end
    drive_idle();
    tick();
  endtask

  // issue one MD op, optionally stalling in DONE, and check timing and result
  task automatic run_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int stall_cycles, input string name);
    ex_t e, got;
    int n;
    logic bad;
    drive(1'b0, op, a, b, 5'd9, 1'b0, 32'h0000CAFE, MEM_OP_NOP, CTRL_NONE, EXP_NONE);
    e = expect_now();
    sb.push_back(e);
    #1;
    checks++;
    if (busy !== 1'b1 || fwd_we_ !== 1'b1) begin
      errors++;
      $display("FAIL %s_issue: got busy=%b fwd_we_=%b expected busy=1 fwd_we_=1", name, busy, fwd_we_);
    end
    n = 1;
    bad = 1'b0;
    tick();
    while (busy === 1'b1 && n < 100) begin
      if (ex_en_ !== 1'b1 || ex_gpr_we_ !== 1'b1 || ex_out !== 32'd0) bad = 1'b1;
      n++;
      tick();
    end
    checks++;
    if (n != 33) begin
      errors++;
      $display("FAIL %s_busy_cycles: got %0d expected 33", name, n);
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s_bubbles: got a non-bubble ex_* while busy expected bubbles", name);
    end
    checks++;
    if (fwd_we_ !== 1'b0 || fwd_out !== e.out) begin
      errors++;
      $display("FAIL %s_done_fwd: got we_=%b out=%h expected we_=0 out=%h", name, fwd_we_, fwd_out, e.out);
    end
    if (stall_cycles > 0) begin
      stall = 1'b1;
      bad = 1'b0;
      repeat (stall_cycles) begin
        tick();
        if (busy !== 1'b0 || ex_en_ !== 1'b1 || ex_out !== 32'd0) bad = 1'b1;
      end
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL %s_stall_hold: got busy=%b en_=%b out=%h expected busy=0 en_=1 out=0",
                 name, busy, ex_en_, ex_out);
      end
      stall = 1'b0;
    end
    tick();
    got = dut_ex();
    e = sb.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s_ex: got %h expected %h", name, got, e);
    end
    // FSM back in IDLE: the still-present MD op would start again
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_idle_after_capture: got busy=%b expected 1", name, busy);
    end
    drive_idle();
    tick();
  endtask

  task automatic test_md_ops();
    run_md(ALU_OP_MUL,  32'h00010000, 32'h00010001, 0, "mul");
    run_md(ALU_OP_DIVU, 32'd100, 32'd7, 0, "divu");
    run_md(ALU_OP_REMU, 32'd100, 32'd7, 0, "remu");
    run_md(ALU_OP_DIVU, 32'd5, 32'd0, 0, "divu_zero");
    run_md(ALU_OP_REMU, 32'd5, 32'd0, 0, "remu_zero");
    run_md(ALU_OP_MUL,  32'hFFFFFFFD, 32'd7, 0, "mul_neg");
  endtask

  task automatic test_flush();
    drive(1'b0, ALU_OP_MUL, 32'd3, 32'd5, 5'd4, 1'b0, 32'd0, MEM_OP_NOP, CTRL_NONE, EXP_NONE);
    repeat (5) tick();
    flush = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_busy: got %b expected 0", busy);
    end
    tick();
    flush = 1'b0;
    checks++;
    if (ex_en_ !== 1'b1 || ex_gpr_we_ !== 1'b1 || ex_out !== 32'd0) begin
      errors++;
      $display("FAIL flush_bubble: got en_=%b we_=%b out=%h expected 1 1 0", ex_en_, ex_gpr_we_, ex_out);
    end
    run_md(ALU_OP_MUL, 32'd123456, 32'd789, 0, "mul_after_flush");
  endtask

  task automatic test_stall_done();
    run_md(ALU_OP_DIVU, 32'hDEADBEEF, 32'd1000, 3, "divu_stall");
  endtask

  task automatic test_reset_mid_run();
    ex_t e, got;
    drive(1'b0, ALU_OP_DIVU, 32'd1000, 32'd3, 5'd2, 1'b0, 32'd0, MEM_OP_NOP, CTRL_NONE, EXP_NONE);
    repeat (10) tick();
    rst = 1'b0;
    #1;
    checks++;
    if (dut_ex() !== RST_EX) begin
      errors++;
      $display("FAIL midrun_reset_ex: got %h expected %h", dut_ex(), RST_EX);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset_busy: got %b expected 0", busy);
    end
    drive(1'b0, ALU_OP_ADDU, 32'd3, 32'd4, 5'd3, 1'b0, 32'd0, MEM_OP_NOP, CTRL_NONE, EXP_NONE);
    e = expect_now();
    sb.push_back(e);
    rst = 1'b1;
    tick();
    got = dut_ex();
    e = sb.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL after_reset_addu: got %h expected %h", got, e);
    end
    drive_idle();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_alu();
    test_md_ops();
    test_flush();
    test_stall_done();
    test_reset_mid_run();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %0d entries expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
